pipe_adder_nbit: RTL and testbench
==================================

# pipe_adder_nbit

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake. It is the sequential successor to the combinational ripple-carry adders used in the multiplier and calculator datapaths. The operand is split into SEG-bit segments, one segment per pipeline stage, with the carry registered between stages, so wide additions (34-bit and up) close timing. It accepts one operation per cycle.

## Interface
- N, default 34: operand and result width, must be ≥ 2.
- SEG, default 8: segment width per stage, 1 ≤ SEG ≤ N.
- STAGES: derived as ceil(N/SEG); not overridable. The last segment is N−(STAGES−1)·SEG bits wide.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- x  in  N  operand A.
- y  in  N  operand B.
- c_in  in  1  carry-in; used only when sub=0.
- sub  in  1  mode: 0 computes x+y+c_in; 1 computes x−y.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- s  out  N  sum or difference, modulo 2^N.
- c_out  out  1  carry out of bit N−1. With sub=1, c_out=1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into bit N−1 XOR carry out of bit N−1.

## Operation
- Subtract mode: effective operand is ~y and effective carry-in is forced to 1; c_in is ignored.
- Stage k (0..STAGES−1) adds segment k of x and the effective y, plus the carry from stage k−1. Stage 0 uses the effective carry-in.
- Upper operand segments are skewed through delay registers, so each stage sees the operands of the same transaction. Lower result segments are delayed so that s is presented whole.
- Each stage carries a valid bit. Bubbles propagate as invalid entries and never produce out_valid.
- Handshake: in_ready = out_ready OR NOT out_valid.
  - Transfer in: in_valid AND in_ready.
  - Transfer out: out_valid AND out_ready.
- Stall: when in_ready=0, every stage register holds, including data, carries and valid bits. s, c_out and ovf stay stable while out_valid=1 and out_ready=0.
- No transaction is dropped, duplicated or reordered.
- ovf and c_out are computed in the final stage from the last segment's MSB carries.

## Timing
- Reset (reset_n=0 at a rising edge): all stage valid bits clear, out_valid=0, s=0, c_out=0, ovf=0. in_ready reads 1 in the cycle after reset.
- Reset mid-stream flushes every in-flight transaction; none emerges afterwards. Reset has priority over in_valid and over stall.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+STAGES−1 and before edge t+STAGES, i.e. STAGES cycles later, when no stall occurs. Each stall cycle adds exactly 1.
- Throughput: 1 operation per cycle while out_ready=1.
- Simultaneous out-transfer and in-transfer in the same cycle are legal and required; there is no bubble insertion.
- STAGES=1 (SEG ≥ N): one registered stage with latency 1; the handshake is unchanged.
- Wrap-around: results are modulo 2^N; c_out and ovf are the only indication of wrap.

## Test plan
- Reset: reset_n=0 for 3 cycles with in_valid=1 and random operands → out_valid=0, s=0, c_out=0, ovf=0 throughout. After release, the first accepted op appears after exactly 5 cycles (N=34, SEG=8).
- Full carry ripple: N=34, SEG=8; x=34'h3_FFFF_FFFF, y=1, c_in=0, sub=0 → s=0, c_out=1, ovf=0. Then x=34'h1_FFFF_FFFF, y=1 → s=34'h2_0000_0000, c_out=0, ovf=1.
- Subtract: x=5, y=7, sub=1, c_in=1 (must be ignored) → s=34'h3_FFFF_FFFE, c_out=0, ovf=0. Then x=7, y=5 → s=2, c_out=1. Then x=34'h2_0000_0000, y=1 → s=34'h1_FFFF_FFFF, ovf=1.
- Streaming and backpressure: 20 back-to-back random ops with out_ready=1, then out_ready=0 for 3 cycles mid-stream → results match a reference model in order. in_ready=0 during the stall, outputs are held stable, and there is no loss or duplicate.
- Parameter sweep: N=16 with SEG ∈ {16, 5, 1}, x=16'hFFFF, y=1 → s=0, c_out=1. Latency is 1, 4 and 16 cycles respectively.
- Reset mid-stream: assert reset_n=0 for 1 cycle with 3 ops in flight → no out_valid from those ops. The next op accepted after reset returns a correct result after STAGES cycles.

Source files
------------

// File: rtl/pipe_adder_nbit.sv
// Pipelined N-bit adder/subtractor, one SEG-bit segment per stage.
// Carries ripple stage to stage; valid/ready with global stall.
module pipe_adder_nbit #(
  parameter int N   = 34,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int STAGES = (N + SEG - 1) / SEG;

  logic         adv;
  logic [N-1:0] y_eff;
  logic         c_eff;

  // Subtract is x + ~y + 1; c_in only matters when adding.
  assign y_eff = sub ? ~y : y;
  assign c_eff = sub | c_in;

  // Whole pipe advances unless the output slot is full and blocked.
  assign in_ready = out_ready | ~out_valid;
  assign adv      = in_ready;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int R  = N - LO;
    localparam int W  = (R < SEG) ? R : SEG;

    // xr/yr hold the not-yet-summed upper operand bits.
    logic [R-1:0]      xr;
    logic [R-1:0]      yr;
    logic              ci;
    logic              vi;
    logic [W:0]        sum;
    logic [LO+W-1:0]   s_d;
    logic [LO+W-1:0]   s_q;
    logic              c_q;
    logic              v_q;

    if (k == 0) begin : g_head
      assign xr  = x;
      assign yr  = y_eff;
      assign ci  = c_eff;
      assign vi  = in_valid;
      assign s_d = sum[W-1:0];
    end else begin : g_link
      assign xr  = g_stage[k-1].g_fwd.x_q;
      assign yr  = g_stage[k-1].g_fwd.y_q;
      assign ci  = g_stage[k-1].c_q;
      assign vi  = g_stage[k-1].v_q;
      assign s_d = {sum[W-1:0], g_stage[k-1].s_q};
    end

    assign sum = {1'b0, xr[W-1:0]}
               + {1'b0, yr[W-1:0]}
               + {{W{1'b0}}, ci};

    // Segment sum, carry and valid advance together.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vi;
        c_q <= sum[W];
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [R-W-1:0] x_q;
      logic [R-W-1:0] y_q;

      // Skew the upper operand bits alongside their transaction.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv) begin
          x_q <= xr[R-1:W];
          y_q <= yr[R-1:W];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit.
      assign ovf_d = xr[R-1] ^ yr[R-1] ^ sum[W-1] ^ sum[W];

      // Overflow flag registered with the final segment.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// Directed bench for pipe_adder_nbit: vectors, stream, stall,
// mid-stream reset and an N=16 segment-width sweep.
module tb_pipe_adder_nbit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] x;
  logic [33:0] y;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] s;
  logic        c_out;
  logic        ovf;

  logic        v16;
  logic [15:0] x16;
  logic [15:0] y16;
  logic        rdy16 [3];
  logic        ov16  [3];
  logic [15:0] s16   [3];
  logic        c16   [3];
  logic        f16   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder_nbit #(.N(34), .SEG(8)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  for (genvar i = 0; i < 3; i++) begin : g16
    localparam int SG = (i == 0) ? 16 : (i == 1) ? 5 : 1;
    pipe_adder_nbit #(.N(16), .SEG(SG)) u_d16 (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (v16),
      .in_ready (rdy16[i]),
      .x        (x16),
      .y        (y16),
      .c_in     (1'b0),
      .sub      (1'b0),
      .out_valid(ov16[i]),
      .out_ready(1'b1),
      .s        (s16[i]),
      .c_out    (c16[i]),
      .ovf      (f16[i])
    );
  end

  typedef struct {
    logic [33:0] x;
    logic [33:0] y;
    logic        ci;
    logic        sb;
    logic [33:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Returns {ovf, c_out, s}
  function automatic logic [35:0] model(input logic [33:0] a,
                                        input logic [33:0] b,
                                        input logic ci, input logic sb);
    logic [33:0] be;
    logic        c0;
    logic [34:0] full;
    logic [33:0] low;
    be   = sb ? ~b : b;
    c0   = sb ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, be} + {34'b0, c0};
    low  = {1'b0, a[32:0]} + {1'b0, be[32:0]} + {33'b0, c0};
    return {low[33] ^ full[34], full[34], full[33:0]};
  endfunction

  function automatic logic [33:0] rnd34();
    return {$urandom_range(3, 0), $urandom()};
  endfunction

  task automatic run_one(input vec_t v, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    x = v.x; y = v.y; c_in = v.ci; sub = v.sb;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    x = rnd34(); y = rnd34(); c_in = 1'b0; sub = 1'b0;
    n = 1; seen = 0;
    while (!seen && n <= 40) begin
      if (out_valid) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({nm, " latency"}, 64'(n), 64'd5);
    chk({nm, " result"}, 64'({ovf, c_out, s}),
        64'({v.eo, v.ec, v.es}));
    @(negedge clk);
    chk({nm, " no dup"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [35:0] q [$];
    logic [35:0] exp;
    logic [35:0] held;
    bit          hold;
    bit          pend;
    int          sent;
    int          got;
    int          extra;
    int          lat [3];
    logic [16:0] r16 [3];

    tbl[0] = '{34'h3_FFFF_FFFF, 34'h1, 1'b0, 1'b0, 34'h0, 1'b1, 1'b0};
    tbl[1] = '{34'h1_FFFF_FFFF, 34'h1, 1'b0, 1'b0,
               34'h2_0000_0000, 1'b0, 1'b1};
    tbl[2] = '{34'h5, 34'h7, 1'b1, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{34'h7, 34'h5, 1'b1, 1'b1, 34'h2, 1'b1, 1'b0};
    tbl[4] = '{34'h2_0000_0000, 34'h1, 1'b0, 1'b1,
               34'h1_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{34'h0, 34'h0, 1'b1, 1'b0, 34'h1, 1'b0, 1'b0};
    tbl[6] = '{34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF, 1'b0, 1'b0,
               34'h3_FFFF_FFFE, 1'b0, 1'b1};
    tbl[7] = '{34'h2_0000_0000, 34'h2_0000_0000, 1'b0, 1'b0,
               34'h0, 1'b1, 1'b1};
    tbl[8] = '{34'h0, 34'h0, 1'b0, 1'b1, 34'h0, 1'b1, 1'b0};
    tbl[9] = '{34'h0FF, 34'h001, 1'b0, 1'b0, 34'h100, 1'b0, 1'b0};

    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x = rnd34(); y = rnd34(); c_in = 1'b1; sub = 1'b0;
    v16 = 1'b1; x16 = 16'hFFFF; y16 = 16'h1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset outs", 64'({out_valid, c_out, ovf, s}), 64'd0);
      chk("reset outs16", 64'({ov16[0], ov16[1], ov16[2]}), 64'd0);
      x = rnd34(); y = rnd34();
    end
    reset_n = 1'b1; in_valid = 1'b0; v16 = 1'b0;
    #1 chk("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      run_one(tbl[i], $sformatf("vec%0d", i));

    sent = 0; got = 0; hold = 0; pend = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 8 && c < 11);
      if (!pend && sent < 20) begin
        x = rnd34(); y = rnd34();
        c_in = 1'($urandom_range(1, 0));
        sub  = 1'($urandom_range(1, 0));
        pend = 1;
      end
      in_valid = pend;
      #1;
      if (hold) begin
        chk("stall hold", 64'({out_valid, ovf, c_out, s}),
            64'({1'b1, held}));
        hold = 0;
      end
      if (c >= 8 && c < 11)
        chk("stall in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream extra", 64'd1, 64'd0);
        end else begin
          exp = q.pop_front();
          chk($sformatf("stream res%0d", got),
              64'({ovf, c_out, s}), 64'(exp));
        end
        got++;
      end
      if (out_valid && !out_ready) begin
        hold = 1;
        held = {ovf, c_out, s};
      end
      if (in_valid && in_ready) begin
        q.push_back(model(x, y, c_in, sub));
        sent++;
        pend = 0;
      end
    end
    chk("stream count", 64'(got), 64'd20);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream no dup", 64'(extra), 64'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x = rnd34(); y = rnd34(); sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midreset flushed", 64'(extra), 64'd0);
    run_one(tbl[1], "after reset");

    @(negedge clk);
    x16 = 16'hFFFF; y16 = 16'h0001; v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0; x16 = 16'h1234; y16 = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      r16[i] = '0;
    end
    for (int n = 1; n <= 20; n++) begin
      for (int i = 0; i < 3; i++)
        if (lat[i] == 0 && ov16[i]) begin
          lat[i] = n;
          r16[i] = {c16[i], s16[i]};
        end
      @(negedge clk);
    end
    chk("n16 seg16 latency", 64'(lat[0]), 64'd1);
    chk("n16 seg5 latency", 64'(lat[1]), 64'd4);
    chk("n16 seg1 latency", 64'(lat[2]), 64'd16);
    for (int i = 0; i < 3; i++)
      chk($sformatf("n16 result%0d", i), 64'(r16[i]), 64'h10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
